// File: rtl/dispatch_rs_ctrl.sv
// Dispatch reserve-stack sequencing controller: push/stall/flush control,
// decode back-pressure, stall statistics and a dispatch-hang watchdog.
module dispatch_rs_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16,
    parameter int MAX_STALL    = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dec_valid_i,
    input  logic             hazard_stall_i,
    input  logic             ex_busy_i,
    input  logic             redirect_i,
    input  logic             fifo_full_i,
    output logic             push_req_o,
    output logic             fifo_stall_o,
    output logic             fifo_flush_o,
    output logic             dec_stall_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] cur_stall_o,
    output logic [CNT_W-1:0] tot_stall_o,
    output logic             watchdog_o
);

    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FW-1:0]    FL_LAST = FW'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_STALL);
    localparam logic [CNT_W-1:0] ALL1    = '1;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        STALL   = 2'd1,
        FLUSH   = 2'd2,
        RECOVER = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [FW-1:0]     fcnt_q, fcnt_d;
    logic [CNT_W-1:0]  cur_q, cur_d;
    logic [CNT_W-1:0]  tot_q, tot_d;
    logic              wd_q, wd_d;
    logic              stall_c;
    logic              stay_stall;

    assign stall_c = hazard_stall_i | ex_busy_i;

    always_comb begin
        state_d      = state_q;
        push_req_o   = 1'b0;
        fifo_stall_o = 1'b0;
        fifo_flush_o = 1'b0;
        unique case (state_q)
            RUN: begin
                fifo_stall_o = stall_c;
                push_req_o   = dec_valid_i & stall_c & ~fifo_full_i;
                if (redirect_i)   state_d = FLUSH;
                else if (stall_c) state_d = STALL;
            end
            STALL: begin
                fifo_stall_o = stall_c;
                push_req_o   = dec_valid_i & ~fifo_full_i;
                if (redirect_i)    state_d = FLUSH;
                else if (!stall_c) state_d = RUN;
            end
            FLUSH: begin
                fifo_flush_o = 1'b1;
                fifo_stall_o = 1'b1;
                if (!redirect_i && fcnt_q == FL_LAST) state_d = RECOVER;
            end
            RECOVER: begin
                fifo_stall_o = 1'b1;
                state_d      = redirect_i ? FLUSH : RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // A redirect inside FLUSH restarts the count, so the flush window is
    // always a full FLUSH_CYCLES after the most recent redirect.
    always_comb begin
        fcnt_d = '0;
        if (state_q == FLUSH && !redirect_i && state_d == FLUSH)
            fcnt_d = fcnt_q + FW'(1);
    end

    assign stay_stall = (state_q == STALL) && (state_d == STALL);

    always_comb begin
        cur_d = '0;
        tot_d = tot_q;
        wd_d  = wd_q;
        if (stay_stall) begin
            cur_d = (cur_q == ALL1) ? cur_q : cur_q + CNT_W'(1);
            if (tot_q != ALL1) tot_d = tot_q + CNT_W'(1);
        end
        if (redirect_i)
            wd_d = 1'b0;
        else if (stay_stall && cur_d == MAX_C)
            wd_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            fcnt_q  <= '0;
            cur_q   <= '0;
            tot_q   <= '0;
            wd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            cur_q   <= cur_d;
            tot_q   <= tot_d;
            wd_q    <= wd_d;
        end
    end

    assign dec_stall_o = fifo_full_i | (state_q == FLUSH);
    assign state_o     = state_q;
    assign cur_stall_o = cur_q;
    assign tot_stall_o = tot_q;
    assign watchdog_o  = wd_q;

endmodule

// File: tb/tb_dispatch_rs_ctrl.sv
// Directed vector-table bench for dispatch_rs_ctrl plus hand sequences
// for stall statistics, flush extension, watchdog and async reset.
module tb_dispatch_rs_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dv, hz, eb, rd, full;
    logic        push, fst, fl, dst, wd;
    logic [1:0]  st;
    logic [15:0] cur, tot;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dispatch_rs_ctrl #(
        .FLUSH_CYCLES(2), .CNT_W(16), .MAX_STALL(255)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .dec_valid_i(dv), .hazard_stall_i(hz), .ex_busy_i(eb),
        .redirect_i(rd), .fifo_full_i(full),
        .push_req_o(push), .fifo_stall_o(fst), .fifo_flush_o(fl),
        .dec_stall_o(dst), .state_o(st), .cur_stall_o(cur),
        .tot_stall_o(tot), .watchdog_o(wd)
    );

    typedef struct {
        logic        dv, hz, eb, rd, full;
        logic        push, fst, fl, dst;
        logic [1:0]  st;
        logic [15:0] cur;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic a, b, c, d, e);
        dv = a; hz = b; eb = c; rd = d; full = e;
    endtask

    task automatic next_cyc();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_state", st, 0);
        chk("rst_cur", cur, 0);
        chk("rst_tot", tot, 0);
        chk("rst_wd", wd, 0);
        chk("rst_flush", fl, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    int peak, fcount, bad_dst, seen_run, wd_ok;

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        //             dv hz eb rd fu  push fst fl dst st  cur
        tbl[0]  = '{1, 0, 0, 0, 0,  0, 0, 0, 0, 2'd0, 16'd0};
        tbl[1]  = '{1, 1, 0, 0, 0,  1, 1, 0, 0, 2'd0, 16'd0};
        tbl[2]  = '{1, 1, 0, 0, 0,  1, 1, 0, 0, 2'd1, 16'd0};
        tbl[3]  = '{1, 0, 1, 0, 1,  0, 1, 0, 1, 2'd1, 16'd1};
        tbl[4]  = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 2'd1, 16'd2};
        tbl[5]  = '{1, 0, 0, 0, 0,  0, 0, 0, 0, 2'd0, 16'd0};
        tbl[6]  = '{1, 1, 0, 1, 0,  1, 1, 0, 0, 2'd0, 16'd0};
        tbl[7]  = '{1, 1, 0, 0, 0,  0, 1, 1, 1, 2'd2, 16'd0};
        tbl[8]  = '{1, 0, 0, 0, 0,  0, 1, 1, 1, 2'd2, 16'd0};
        tbl[9]  = '{1, 1, 0, 1, 0,  0, 1, 0, 0, 2'd3, 16'd0};
        tbl[10] = '{0, 0, 0, 0, 0,  0, 1, 1, 1, 2'd2, 16'd0};
        tbl[11] = '{0, 0, 0, 0, 1,  0, 1, 1, 1, 2'd2, 16'd0};
        tbl[12] = '{0, 0, 0, 0, 0,  0, 1, 0, 0, 2'd3, 16'd0};
        tbl[13] = '{1, 0, 1, 0, 0,  1, 1, 0, 0, 2'd0, 16'd0};
        tbl[14] = '{0, 0, 1, 0, 0,  0, 1, 0, 0, 2'd1, 16'd0};
        tbl[15] = '{1, 0, 0, 1, 0,  1, 0, 0, 0, 2'd1, 16'd1};
        tbl[16] = '{0, 0, 0, 0, 0,  0, 1, 1, 1, 2'd2, 16'd0};
        tbl[17] = '{0, 0, 0, 0, 0,  0, 1, 1, 1, 2'd2, 16'd0};
        tbl[18] = '{0, 0, 0, 0, 0,  0, 1, 0, 0, 2'd3, 16'd0};
        tbl[19] = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 2'd0, 16'd0};

        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].dv, tbl[i].hz, tbl[i].eb, tbl[i].rd, tbl[i].full);
            @(negedge clk);
            chk($sformatf("v%0d_push", i), push, tbl[i].push);
            chk($sformatf("v%0d_fstall", i), fst, tbl[i].fst);
            chk($sformatf("v%0d_flush", i), fl, tbl[i].fl);
            chk($sformatf("v%0d_dstall", i), dst, tbl[i].dst);
            chk($sformatf("v%0d_state", i), st, tbl[i].st);
            chk($sformatf("v%0d_cur", i), cur, tbl[i].cur);
            next_cyc();
        end
        chk("tbl_tot", tot, 3);

        // idle with valid decode
        do_reset();
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_state", st, 0);
            chk("idle_push", push, 0);
            chk("idle_fstall", fst, 0);
            chk("idle_cnt", cur + tot, 0);
            next_cyc();
        end

        // 5-cycle hazard
        do_reset();
        peak = 0;
        drive(1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hz_push", push, 1);
            chk("hz_state", st, (i == 0) ? 0 : 1);
            if (cur > peak) peak = cur;
            next_cyc();
        end
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        if (cur > peak) peak = cur;
        next_cyc();
        @(negedge clk);
        chk("hz_peak", peak, 4);
        chk("hz_cur_rel", cur, 0);
        chk("hz_state_rel", st, 0);
        chk("hz_tot", tot, 4);

        // redirect from STALL, then redirect on first FLUSH cycle
        for (int t = 0; t < 2; t++) begin
            do_reset();
            drive(1, 1, 0, 0, 0);
            next_cyc();
            next_cyc();
            drive(1, 1, 0, 1, 0);
            @(negedge clk);
            chk("rd_in_stall", st, 1);
            next_cyc();
            drive(0, 0, 0, (t == 1), 0);
            fcount = 0; bad_dst = 0; seen_run = 0;
            for (int c = 0; c < 12 && seen_run == 0; c++) begin
                @(negedge clk);
                if (fl) fcount++;
                if (dst != (st == 2'd2)) bad_dst++;
                if (st == 2'd3) begin
                    next_cyc();
                    @(negedge clk);
                    seen_run = (st == 2'd0) ? 1 : 2;
                end
                next_cyc();
                drive(0, 0, 0, 0, 0);
            end
            chk(t ? "ext_flush_len" : "flush_len", fcount, t ? 3 : 2);
            chk("flush_dstall", bad_dst, 0);
            chk("recover_to_run", seen_run, 1);
        end

        // watchdog
        do_reset();
        wd_ok = 1;
        drive(0, 0, 1, 0, 0);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cur >= 255 && !wd) wd_ok = 0;
            if (cur < 255 && wd) wd_ok = 0;
            next_cyc();
        end
        chk("wd_timing", wd_ok, 1);
        drive(0, 0, 0, 0, 0);
        next_cyc();
        @(negedge clk);
        chk("wd_state", st, 0);
        chk("wd_sticky", wd, 1);
        chk("wd_tot", tot, 299);
        next_cyc();
        drive(0, 0, 0, 1, 0);
        next_cyc();
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("wd_clear", wd, 0);

        // full in STALL, async reset mid-FLUSH
        do_reset();
        drive(1, 1, 0, 0, 0);
        next_cyc();
        drive(1, 1, 0, 0, 1);
        @(negedge clk);
        chk("full_dstall", dst, 1);
        chk("full_nopush", push, 0);
        next_cyc();
        drive(0, 0, 0, 1, 0);
        next_cyc();
        drive(0, 0, 0, 0, 0);
        #2;
        chk("pre_rst_flush", fl, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_flush", fl, 0);
        chk("arst_state", st, 0);
        next_cyc();
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
